// File: rtl/result_collector.sv
// Result collector: numbers validator results and buffers winning ones in a first-word-fall-through FIFO.
// Optional win statistics output (win_count) enabled by defining RESULT_COLLECTOR_STATS_EN.
module result_collector #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned NONCE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic                   newblock_i,
  input  logic                   success_i,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [NONCE_WIDTH-1:0] result_nonce,
  output logic [7:0]             result_block,
`ifdef RESULT_COLLECTOR_STATS_EN
  output logic [15:0]            win_count,
`endif
  output logic                   overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [NONCE_WIDTH-1:0] r_nonce;
  logic [7:0]             r_block;
  logic [NONCE_WIDTH-1:0] r_mem_nonce [FIFO_DEPTH];
  logic [7:0]             r_mem_block [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_valid;
  logic                   r_overflow;

  logic                   w_newblk;
  logic [NONCE_WIDTH-1:0] w_cur_nonce;
  logic [7:0]             w_cur_block;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push_req;
  logic                   w_push;
  logic                   w_drop;
  logic [CW-1:0]          w_count_nxt;

  // Current result numbering and FIFO push/pop decisions.
  always_comb begin
    w_newblk    = valid_i && newblock_i;
    w_cur_nonce = w_newblk ? '0 : r_nonce;
    w_cur_block = w_newblk ? (r_block + 8'd1) : r_block;
    w_full      = (r_count == CW'(FIFO_DEPTH));
    w_pop       = r_valid && result_ready;
    w_push_req  = valid_i && success_i;
    w_push      = w_push_req && (!w_full || w_pop);
    w_drop      = w_push_req && w_full && !w_pop;
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nonce    <= '0;
      r_block    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_nonce[i] <= '0;
        r_mem_block[i] <= '0;
      end
    end else begin
      if (valid_i) begin
        r_nonce <= w_cur_nonce + NONCE_WIDTH'(1);
        r_block <= w_cur_block;
      end
      if (w_push) begin
        r_mem_nonce[r_wr_ptr] <= w_cur_nonce;
        r_mem_block[r_wr_ptr] <= w_cur_block;
        r_wr_ptr              <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef RESULT_COLLECTOR_STATS_EN
  logic [15:0] r_win_count;

  // Accepted pushes only, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win_count <= '0;
    end else if (w_push && (r_win_count != 16'hFFFF)) begin
      r_win_count <= r_win_count + 16'd1;
    end
  end

  assign win_count = r_win_count;
`endif

  assign result_valid = r_valid;
  assign result_nonce = r_mem_nonce[r_rd_ptr];
  assign result_block = r_mem_block[r_rd_ptr];
  assign overflow     = r_overflow;

endmodule
